// File: rtl/fpu_exception_irq.sv
// fpu_exception_irq
//   Consumer side of the FPU status word. Decides when an unmasked exception
//   must interrupt the CPU, runs the int_req/int_ack handshake, and resolves
//   FWAIT requests. It waits for Busy to clear, then reports either clean
//   completion or an exception fault.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   status_word   [15] Busy, [5:0] PE,UE,OE,ZE,DE,IE
//   control_word  [5:0] exception masks (1 = masked), [7] IEM
//   int_ack       CPU/PIC acknowledge pulse
//   wait_req      FWAIT issued pulse
//   int_req       interrupt request level to CPU
//   exc_cause     unmasked exception bits captured on entry to RAISE
//   wait_done     one-cycle pulse: FWAIT completed cleanly
//   wait_fault    one-cycle pulse: FWAIT hit a pending unmasked exception
//   ack_timeout   sticky: int_req left unacknowledged for ACK_TIMEOUT cycles
//
// Optional feature (macro FPU_EXC_IRQ_COUNT_EN)
//   irq_count     [15:0] number of entries into RAISE, wraps
//   irq_count_clr synchronous clear, wins over a same-cycle increment
//
// State table
//   state       | meaning
//   S_IDLE      | no request outstanding
//   S_WAIT_BUSY | FWAIT pending, waiting for Busy to drop
//   S_RAISE     | int_req asserted, waiting for int_ack
//   S_ACKED     | acknowledged, waiting for the handler to clear exceptions

module fpu_exception_irq #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] status_word,
  input  logic [15:0] control_word,
  input  logic        int_ack,
  input  logic        wait_req,
  output logic        int_req,
  output logic [5:0]  exc_cause,
  output logic        wait_done,
  output logic        wait_fault,
  output logic        ack_timeout
`ifdef FPU_EXC_IRQ_COUNT_EN
  ,
  output logic [15:0] irq_count,
  input  logic        irq_count_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_RAISE     = 2'd2,
    S_ACKED     = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] LP_TO = TIMEOUT_W'(ACK_TIMEOUT);

  state_t               r_state, w_state_nxt;
  logic                 r_int_req, w_int_req_nxt;
  logic [5:0]           r_exc_cause, w_exc_cause_nxt;
  logic                 r_wait_done, w_wait_done_nxt;
  logic                 r_wait_fault, w_wait_fault_nxt;
  logic                 r_ack_timeout, w_ack_timeout_nxt;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                 w_raise_entry;

  logic [5:0] w_unmasked;
  logic       w_irq_cond;
  logic       w_busy;
  logic       w_unused;

  assign w_unmasked = status_word[5:0] & ~control_word[5:0];
  assign w_irq_cond = (|w_unmasked) & ~control_word[7];
  assign w_busy     = status_word[15];
  assign w_unused   = ^{status_word[14:6], control_word[15:8], control_word[6]};

  // Saturating increment so a very long unacknowledged request cannot wrap.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt       = r_state;
    w_int_req_nxt     = r_int_req;
    w_exc_cause_nxt   = r_exc_cause;
    w_wait_done_nxt   = 1'b0;
    w_wait_fault_nxt  = 1'b0;
    w_ack_timeout_nxt = r_ack_timeout;
    w_cnt_nxt         = r_cnt;
    w_raise_entry     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_irq_cond) begin
          w_state_nxt     = S_RAISE;
          w_int_req_nxt   = 1'b1;
          w_exc_cause_nxt = w_unmasked;
          w_cnt_nxt       = '0;
          w_raise_entry   = 1'b1;
        end else if (wait_req) begin
          if (w_busy) w_state_nxt = S_WAIT_BUSY;
          else        w_wait_done_nxt = 1'b1;
        end
      end

      S_WAIT_BUSY: begin
        if (!w_busy) begin
          if (w_irq_cond) begin
            w_wait_fault_nxt = 1'b1;
            w_state_nxt      = S_RAISE;
            w_int_req_nxt    = 1'b1;
            w_exc_cause_nxt  = w_unmasked;
            w_cnt_nxt        = '0;
            w_raise_entry    = 1'b1;
          end else begin
            w_wait_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end
      end

      S_RAISE: begin
        w_wait_fault_nxt = wait_req;
        // Acknowledge wins over a simultaneous fall of irq_cond.
        if (int_ack) begin
          w_state_nxt       = S_ACKED;
          w_int_req_nxt     = 1'b0;
          w_cnt_nxt         = '0;
          w_ack_timeout_nxt = 1'b0;
        end else if (!w_irq_cond) begin
          w_state_nxt   = S_IDLE;
          w_int_req_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if ((ACK_TIMEOUT != 0) && (w_cnt_inc >= LP_TO)) w_ack_timeout_nxt = 1'b1;
        end
      end

      S_ACKED: begin
        w_wait_fault_nxt = wait_req;
        // Hold off until the handler clears the cause, so it is not re-raised.
        if (!w_irq_cond) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_int_req     <= 1'b0;
      r_exc_cause   <= '0;
      r_wait_done   <= 1'b0;
      r_wait_fault  <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_int_req     <= w_int_req_nxt;
      r_exc_cause   <= w_exc_cause_nxt;
      r_wait_done   <= w_wait_done_nxt;
      r_wait_fault  <= w_wait_fault_nxt;
      r_ack_timeout <= w_ack_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign int_req     = r_int_req;
  assign exc_cause   = r_exc_cause;
  assign wait_done   = r_wait_done;
  assign wait_fault  = r_wait_fault;
  assign ack_timeout = r_ack_timeout;

`ifdef FPU_EXC_IRQ_COUNT_EN
  logic [15:0] r_irq_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_irq_count <= '0;
    else if (irq_count_clr) r_irq_count <= '0;
    else if (w_raise_entry) r_irq_count <= r_irq_count + 16'd1;
  end

  assign irq_count = r_irq_count;
`else
  logic w_unused_entry;
  assign w_unused_entry = w_raise_entry;
`endif

endmodule
